// File: rtl/inst_mem_pkg.sv
// Shared definitions for the loadable instruction memory and the fetch/decode logic
// that consumes it: default geometry, NOP fill value and the load FSM state type.
package inst_mem_pkg;

  localparam int IW_DEFAULT = 10;
  localparam int DW_DEFAULT = 9;
  localparam logic [DW_DEFAULT-1:0] NOP_DEFAULT = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/inst_mem_array.sv
// Program storage: 2**AW x DW words, synchronous write, registered read.
// The read register only updates on rd_en, so the last fetched word is held.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int AW = IW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_loadable.sv
// Run-time loadable instruction memory: valid/ready program load stream, then a
// one-cycle-latency fetch port with bounds checking against the loaded length.
module inst_mem_loadable
  import inst_mem_pkg::*;
#(
  parameter int            IW  = IW_DEFAULT,
  parameter int            DW  = DW_DEFAULT,
  parameter logic [DW-1:0] NOP = DW'(NOP_DEFAULT)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          LoadStart,
  input  logic          LoadValid,
  input  logic [DW-1:0] LoadData,
  input  logic          LoadLast,
  output logic          LoadReady,
  output logic          LoadErr,
  output logic [IW:0]   Loaded,
  output logic          Ready,
  input  logic          ReqValid,
  input  logic [IW-1:0] InstAddress,
  output logic          RespValid,
  output logic [DW-1:0] InstOut,
  output logic          AddrFault
);

  localparam logic [IW:0] ONE      = {{IW{1'b0}}, 1'b1};
  localparam logic [IW:0] LAST_IDX = {1'b0, {IW{1'b1}}};

  state_t      state_q, state_d;
  logic [IW:0] loaded_q, loaded_d;
  logic        load_err_q, load_err_d;
  logic        load_ready_q, load_ready_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        addr_fault_q, addr_fault_d;
  logic        sel_mem_q, sel_mem_d;

  logic          wr_en;
  logic          rd_en;
  logic          req_run;
  logic          out_of_range;
  logic [DW-1:0] rd_data;

  // Load FSM. The write pointer is the low bits of the word count, since the
  // two always advance together while loading.
  always_comb begin
    state_d    = state_q;
    loaded_d   = loaded_q;
    load_err_d = load_err_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (LoadStart) begin
          state_d    = LOAD;
          loaded_d   = '0;
          load_err_d = 1'b0;
        end
      end
      LOAD: begin
        if (LoadStart) begin
          loaded_d   = '0;
          load_err_d = 1'b0;
        end else if (LoadValid) begin
          wr_en    = 1'b1;
          loaded_d = loaded_q + ONE;
          if (LoadLast) begin
            state_d = RUN;
          end else if (loaded_q == LAST_IDX) begin
            load_err_d = 1'b1;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (LoadStart) begin
          state_d    = LOAD;
          loaded_d   = '0;
          load_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    load_ready_d = (state_d == LOAD);
    ready_d      = (state_d == RUN);
  end

  // Fetch path: the bounds check uses the length seen at request time, so a
  // request that coincides with LoadStart still completes against the old program.
  always_comb begin
    req_run      = ReqValid && (state_q == RUN);
    out_of_range = ({1'b0, InstAddress} >= loaded_q);
    resp_valid_d = req_run;
    addr_fault_d = req_run && out_of_range;
    rd_en        = req_run && !out_of_range;
    sel_mem_d    = ReqValid ? rd_en : sel_mem_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      loaded_q     <= '0;
      load_err_q   <= 1'b0;
      load_ready_q <= 1'b0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      addr_fault_q <= 1'b0;
      sel_mem_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      loaded_q     <= loaded_d;
      load_err_q   <= load_err_d;
      load_ready_q <= load_ready_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      addr_fault_q <= addr_fault_d;
      sel_mem_q    <= sel_mem_d;
    end
  end

  inst_mem_array #(
    .AW (IW),
    .DW (DW)
  ) u_array (
    .clk     (Clk),
    .wr_en   (wr_en),
    .wr_addr (loaded_q[IW-1:0]),
    .wr_data (LoadData),
    .rd_en   (rd_en),
    .rd_addr (InstAddress),
    .rd_data (rd_data)
  );

  assign LoadReady = load_ready_q;
  assign LoadErr   = load_err_q;
  assign Loaded    = loaded_q;
  assign Ready     = ready_q;
  assign RespValid = resp_valid_q;
  assign AddrFault = addr_fault_q;
  assign InstOut   = sel_mem_q ? rd_data : NOP;

endmodule
